fixed_to_fp19: RTL and testbench

//  Multi-cycle converter: signed two's-complement fixed-point -> 19-bit float {sign[18], exp[17:10] bias 127, mant[9:0]}.

---
 rtl/fixed_to_fp19.sv | 138 +++++++++++++
 tb/tb_fixed_to_fp19.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_fp19.sv
// fixed_to_fp19: multi-cycle converter from signed two's-complement fixed-point
// (value = in_data / 2^FRAC_W) to fp19 {sign[18], exp[17:10] bias 127, mant[9:0]}.
// Valid/ready on both sides, iterative leading-one normalization and
// round-to-nearest-even. One conversion in flight at a time.
// Optional build macro FIXED_TO_FP19_FAST_NORM_EN: normalization skips four
// leading zeros per cycle when it can; results are bit-identical, only latency changes.
module fixed_to_fp19 #(
  parameter int IN_W   = 24,  // legal 13..64
  parameter int FRAC_W = 12   // legal 0..IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [18:0]     out_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  // Biased exponent when the leading one already sits at bit IN_W-1.
  // Range for legal parameters is 63..190, so 8 bits never wrap.
  localparam logic [7:0] E_INIT = 8'(IN_W - 1 - FRAC_W + 127);

  state_t          state_q;
  logic            sign_q;
  logic [IN_W-1:0] sh_q;
  logic [7:0]      e_q;
  logic            out_valid_q;
  logic [18:0]     out_data_q;

  // Magnitude of the incoming operand; the most negative value maps to
  // 2^(IN_W-1), which still fits exactly as an unsigned IN_W-bit number.
  logic [IN_W-1:0] mag_d;
  assign mag_d = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

  // Round-to-nearest-even of the normalized shift register: the 10 bits below
  // the leading one are the mantissa, the next bit is guard, the rest sticky.
  logic [9:0]  rnd_m_d;
  logic        rnd_g_d;
  logic        rnd_s_d;
  logic        rnd_up_d;
  logic [10:0] rnd_sum_d;
  logic [9:0]  rnd_mant_d;
  logic [7:0]  rnd_exp_d;

  always_comb begin
    rnd_m_d    = sh_q[IN_W-2 -: 10];
    rnd_g_d    = sh_q[IN_W-12];
    rnd_s_d    = |sh_q[IN_W-13:0];
    rnd_up_d   = rnd_g_d & (rnd_s_d | rnd_m_d[0]);
    rnd_sum_d  = {1'b0, rnd_m_d} + 11'(rnd_up_d);
    rnd_mant_d = rnd_sum_d[9:0];
    rnd_exp_d  = e_q;
    // A carry out of the mantissa means it overflowed to 1.000..., so the
    // mantissa field becomes zero and the exponent steps up by one.
    if (rnd_sum_d[10]) begin
      rnd_mant_d = '0;
      rnd_exp_d  = e_q + 8'd1;
    end
  end

  // Conversion FSM: capture, normalize, round, then hold the result until taken.
  // NOTE: every register is cleared by the asynchronous reset so an interrupted
  // conversion leaves no stale data behind; state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      sh_q        <= '0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sh_q <= mag_d;
            e_q  <= E_INIT;
            if (mag_d == '0) begin
              // Zero has no leading one; emit +0 directly.
              sign_q     <= 1'b0;
              out_data_q <= 19'h0;
              state_q    <= S_DONE;
            end else begin
              sign_q  <= in_data[IN_W-1];
              state_q <= S_NORM;
            end
          end
        end

        S_NORM: begin
          if (sh_q[IN_W-1]) begin
            state_q <= S_ROUND;
`ifdef FIXED_TO_FP19_FAST_NORM_EN
          end else if (sh_q[IN_W-1 -: 4] == 4'd0) begin
            sh_q <= sh_q << 4;
            e_q  <= e_q - 8'd4;
`endif
          end else begin
            sh_q <= sh_q << 1;
            e_q  <= e_q - 8'd1;
          end
        end

        S_ROUND: begin
          out_data_q <= {sign_q, rnd_exp_d, rnd_mant_d};
          state_q    <= S_DONE;
        end

        S_DONE: begin
          // out_valid rises one cycle after entering DONE and then holds
          // until the downstream handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_to_fp19.sv
// Self-checking bench for fixed_to_fp19 (IN_W=24, FRAC_W=12): a driver issues
// directed and random operands and pushes the expected fp19 word and latency
// into a scoreboard; a monitor pops and compares whenever out_valid is seen.
module tb_fixed_to_fp19;
  localparam int IN_W   = 24;
  localparam int FRAC_W = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [18:0]     out_data;

  fixed_to_fp19 #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [18:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_miss   = 0;
  int   stall_cnt = 0;
  bit   seen = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: value = d / 2^FRAC_W. Find the leading one, take the next 10
  // bits as mantissa and round the remainder to nearest, ties to even.
  function automatic exp_t model(input logic [IN_W-1:0] d);
    exp_t           r;
    bit             sgn;
    longint unsigned dv, mag, frac, q, rem, half;
    int             p, expo, sh, n, steps;
    sgn = d[IN_W-1];
    dv  = {40'd0, d};
    mag = sgn ? (64'd16777216 - dv) : dv;
    r.acc = 0;
    if (mag == 0) begin
      r.data = 19'h0;
      r.lat  = 1;
      return r;
    end
    p = 0;
    for (int i = 0; i < IN_W; i++) if (mag[i]) p = i;
    expo = p - FRAC_W + 127;
    frac = mag - (64'd1 << p);
    if (p >= 10) begin
      sh  = p - 10;
      q   = frac >> sh;
      rem = frac - (q << sh);
      if (sh > 0) begin
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end else begin
      q = frac << (10 - p);
    end
    if (q == 1024) begin
      q = 0;
      expo++;
    end
    r.data = {sgn, 8'(expo), 10'(q)};
    n = IN_W - 1 - p;
`ifdef FIXED_TO_FP19_FAST_NORM_EN
    steps = n / 4 + n % 4;
`else
    steps = n;
`endif
    r.lat = steps + 3;
    return r;
  endfunction

  // Offer one operand; junk in_valid pulses are driven while the DUT is busy.
  task automatic send(input logic [IN_W-1:0] d);
    exp_t e;
    int   tries = 0;
    while (!in_ready && tries < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = IN_W'($urandom);
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      e        = model(d);
      e.acc    = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = IN_W'($urandom);
    end
  endtask

  // Monitor: compare the presented result, then choose out_ready for the next edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen      = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!seen) begin
            check("latency", cyc - sb_q[0].acc, sb_q[0].lat);
            seen = 1'b1;
          end
          check("out_data", out_data, sb_q[0].data);
          check("in_ready_busy", in_ready, 0);
        end
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        if (out_ready && sb_q.size() != 0) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [IN_W-1:0] directed [8] = '{24'h001000, 24'hFFE800, 24'h000FFF, 24'h000000,
                                     24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};

  initial begin
    logic [IN_W-1:0] d;
    int              wait_cnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    foreach (directed[i]) send(directed[i]);

    // Backpressure: hold out_ready low for five valid cycles.
    stall_cnt = 5;
    send(24'h001000);
    send(24'hFFE800);

    // Reset in the middle of normalization, then a clean conversion.
    send(24'h000001);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(24'h001000);

    for (int k = 0; k < 150; k++) begin
      d = IN_W'($urandom >> $urandom_range(8, 31));
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 20) == 0) d = '0;
      send(d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 500) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
